// File: rtl/watch_timekeeper.sv
// watch_timekeeper: turns the divided slow toggle from the clock divider into
// a BCD 24-hour hh:mm:ss time of day, with a small RUN / SET_HR / SET_MIN
// mode machine driven by debounced single-cycle pulses. slow_in is treated
// as an asynchronous data input and is never used as a clock.
module watch_timekeeper #(
  parameter bit BOTH_EDGES = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slow_in,
  input  logic       mode_p,
  input  logic       inc_p,
  output logic [3:0] hr_t,
  output logic [3:0] hr_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic [1:0] mode_o,
  output logic       tick_o
);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_BAD     = 2'd3
  } mode_e;

  // synchronizer chain: s1 absorbs metastability, s2/s3 form the edge detector
  logic s1_q, s2_q, s3_q;
  logic tick;

  mode_e      mode_q, mode_d;
  logic [3:0] hr_t_q, hr_t_d, hr_u_q, hr_u_d;
  logic [3:0] min_t_q, min_t_d, min_u_q, min_u_d;
  logic [3:0] sec_t_q, sec_t_d, sec_u_q, sec_u_d;
  logic       tick_o_q, tick_o_d;

  // candidate increments, computed once and selected by the mode machine
  logic [8:0] sec_inc, min_inc;
  logic [7:0] hr_inc;

  // Single digit compare-and-wrap: anything at or above max returns to 0,
  // so a corrupted digit can never count into an illegal code.
  function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

  // Two-digit 00..59 increment. Bit 8 is the carry out of 59 -> 00.
  function automatic logic [8:0] sixty_inc(input logic [3:0] t, input logic [3:0] u);
    logic       carry;
    logic [3:0] nt;
    logic [3:0] nu;
    carry = (u >= 4'd9) && (t >= 4'd5);
    nt    = (u >= 4'd9) ? wrap_inc(t, 4'd5) : t;
    nu    = wrap_inc(u, 4'd9);
    return {carry, nt, nu};
  endfunction

  // Hours 00..23 increment; 23 (or anything past it) wraps to 00, x9 -> (x+1)0.
  function automatic logic [7:0] hours_inc(input logic [3:0] t, input logic [3:0] u);
    if ((t >= 4'd2) && (u >= 4'd3)) begin
      return 8'h00;
    end
    if (u >= 4'd9) begin
      return {wrap_inc(t, 4'd2), 4'd0};
    end
    return {t, u + 4'd1};
  endfunction

  // rising edge only, or either edge, of the synchronized slow signal
  assign tick = BOTH_EDGES ? (s2_q ^ s3_q) : (s2_q & ~s3_q);

  // next-state logic: mode_p has priority over both tick and inc_p
  always_comb begin
    mode_d   = mode_q;
    hr_t_d   = hr_t_q;
    hr_u_d   = hr_u_q;
    min_t_d  = min_t_q;
    min_u_d  = min_u_q;
    sec_t_d  = sec_t_q;
    sec_u_d  = sec_u_q;
    tick_o_d = 1'b0;
    sec_inc  = sixty_inc(sec_t_q, sec_u_q);
    min_inc  = sixty_inc(min_t_q, min_u_q);
    hr_inc   = hours_inc(hr_t_q, hr_u_q);

    case (mode_q)
      MODE_RUN: begin
        if (mode_p) begin
          // a tick landing on the same edge is deliberately dropped
          mode_d = MODE_SET_HR;
        end else if (tick) begin
          tick_o_d         = 1'b1;
          {sec_t_d, sec_u_d} = sec_inc[7:0];
          if (sec_inc[8]) begin
            {min_t_d, min_u_d} = min_inc[7:0];
            if (min_inc[8]) begin
              {hr_t_d, hr_u_d} = hr_inc;
            end
          end
        end
      end
      MODE_SET_HR: begin
        if (mode_p) begin
          mode_d = MODE_SET_MIN;
        end else if (inc_p) begin
          {hr_t_d, hr_u_d} = hr_inc;
        end
      end
      MODE_SET_MIN: begin
        if (mode_p) begin
          // leaving set mode starts the new minute from :00
          mode_d  = MODE_RUN;
          sec_t_d = 4'd0;
          sec_u_d = 4'd0;
        end else if (inc_p) begin
          // minutes wrap on their own, no carry into the hours here
          {min_t_d, min_u_d} = min_inc[7:0];
        end
      end
      default: begin
        mode_d = MODE_RUN;
      end
    endcase
  end

  // all state, with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      mode_q   <= MODE_RUN;
      hr_t_q   <= 4'd0;
      hr_u_q   <= 4'd0;
      min_t_q  <= 4'd0;
      min_u_q  <= 4'd0;
      sec_t_q  <= 4'd0;
      sec_u_q  <= 4'd0;
      tick_o_q <= 1'b0;
    end else begin
      s1_q     <= slow_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      mode_q   <= mode_d;
      hr_t_q   <= hr_t_d;
      hr_u_q   <= hr_u_d;
      min_t_q  <= min_t_d;
      min_u_q  <= min_u_d;
      sec_t_q  <= sec_t_d;
      sec_u_q  <= sec_u_d;
      tick_o_q <= tick_o_d;
    end
  end

  assign hr_t   = hr_t_q;
  assign hr_u   = hr_u_q;
  assign min_t  = min_t_q;
  assign min_u  = min_u_q;
  assign sec_t  = sec_t_q;
  assign sec_u  = sec_u_q;
  assign mode_o = mode_q;
  assign tick_o = tick_o_q;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Bench for watch_timekeeper: a rising-edge instance exercised with directed
// and random events against a seconds-of-day model, plus a both-edges instance.
module tb_watch_timekeeper;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic slow0 = 1'b0, mode_p0 = 1'b0, inc_p0 = 1'b0;
  logic slow1 = 1'b0, mode_p1 = 1'b0, inc_p1 = 1'b0;
  logic [3:0] hr_t0, hr_u0, min_t0, min_u0, sec_t0, sec_u0;
  logic [3:0] hr_t1, hr_u1, min_t1, min_u1, sec_t1, sec_u1;
  logic [1:0] mode_o0, mode_o1;
  logic       tick_o0, tick_o1;

  int total = 0;
  int bad   = 0;

  // model: time as seconds of the day, mode as 0/1/2
  int m_secs = 0;
  int m_mode = 0;

  always #5 clk = ~clk;

  watch_timekeeper #(.BOTH_EDGES(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .slow_in(slow0), .mode_p(mode_p0), .inc_p(inc_p0),
    .hr_t(hr_t0), .hr_u(hr_u0), .min_t(min_t0), .min_u(min_u0),
    .sec_t(sec_t0), .sec_u(sec_u0), .mode_o(mode_o0), .tick_o(tick_o0)
  );

  watch_timekeeper #(.BOTH_EDGES(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .slow_in(slow1), .mode_p(mode_p1), .inc_p(inc_p1),
    .hr_t(hr_t1), .hr_u(hr_u1), .min_t(min_t1), .min_u(min_u1),
    .sec_t(sec_t1), .sec_u(sec_u1), .mode_o(mode_o1), .tick_o(tick_o1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag);
    int h, m, s;
    h = m_secs / 3600;
    m = (m_secs / 60) % 60;
    s = m_secs % 60;
    check({tag, ".hr_t"},  hr_t0,  h / 10);
    check({tag, ".hr_u"},  hr_u0,  h % 10);
    check({tag, ".min_t"}, min_t0, m / 10);
    check({tag, ".min_u"}, min_u0, m % 10);
    check({tag, ".sec_t"}, sec_t0, s / 10);
    check({tag, ".sec_u"}, sec_u0, s % 10);
    check({tag, ".mode"},  mode_o0, m_mode);
  endtask

  // one 20-cycle period of slow0, high for 'hi' cycles
  task automatic slow_pulse(input string tag, input int hi);
    bit run;
    run = (m_mode == 0);
    slow0 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == hi) slow0 = 1'b0;
      check({tag, ".tick_o"}, tick_o0, (run && i == 3) ? 1 : 0);
    end
    slow0 = 1'b0;
    if (run) m_secs = (m_secs + 1) % 86400;
    check_time(tag);
  endtask

  // one cycle of mode_p / inc_p
  task automatic pulse(input bit mp, input bit ip);
    int h, m, s;
    mode_p0 = mp;
    inc_p0  = ip;
    step();
    mode_p0 = 1'b0;
    inc_p0  = 1'b0;
    if (mp) begin
      if (m_mode == 2) m_secs = m_secs - (m_secs % 60);
      m_mode = (m_mode + 1) % 3;
    end else if (ip) begin
      h = m_secs / 3600;
      m = (m_secs / 60) % 60;
      s = m_secs % 60;
      if (m_mode == 1) h = (h + 1) % 24;
      if (m_mode == 2) m = (m + 1) % 60;
      m_secs = h * 3600 + m * 60 + s;
    end
  endtask

  task automatic set_time(input int h, input int m);
    int n;
    while (m_mode != 0) pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    n = (h - m_secs / 3600 + 24) % 24;
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    n = (m - (m_secs / 60) % 60 + 60) % 60;
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
  endtask

  initial begin
    int cnt, ev;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset.tick_o", tick_o0, 0);
    check_time("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    check_time("post_reset");

    // five ticks from 00:00:00, tick_o three edges after each rise
    for (int k = 0; k < 5; k++) slow_pulse("run5", $urandom_range(1, 12));
    check("run5.sec_u", sec_u0, 5);

    // rollover
    set_time(23, 59);
    check_time("set2359");
    for (int k = 0; k < 59; k++) slow_pulse("roll59", $urandom_range(1, 12));
    check("roll.sec_t", sec_t0, 5);
    check("roll.sec_u", sec_u0, 9);
    slow_pulse("roll_wrap", $urandom_range(1, 12));
    check("roll.hr_t", hr_t0, 0);
    check("roll.hr_u", hr_u0, 0);
    check("roll.min_t", min_t0, 0);

    // set mode: 25 hour incs pass through 23 -> 00, then 61 minute incs
    pulse(1'b1, 1'b0);
    check_time("sethr.enter");
    for (int k = 0; k < 25; k++) begin
      pulse(1'b0, 1'b1);
      check_time("sethr.inc");
    end
    check("sethr.hr_u", hr_u0, 1);
    pulse(1'b1, 1'b0);
    for (int k = 0; k < 61; k++) begin
      pulse(1'b0, 1'b1);
      check_time("setmin.inc");
    end
    check("setmin.min_u", min_u0, 1);
    check("setmin.hr_u", hr_u0, 1);
    pulse(1'b1, 1'b0);
    check_time("setmin.exit");
    check("exit.mode", mode_o0, 0);

    // ticks ignored in SET_HR (10 edges)
    for (int k = 0; k < 3; k++) slow_pulse("pre_ign", $urandom_range(1, 12));
    pulse(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) slow_pulse("ignored", $urandom_range(1, 12));
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check_time("back_run");

    // mode_p with inc_p from RUN
    for (int k = 0; k < 4; k++) slow_pulse("pre_sim", $urandom_range(1, 12));
    pulse(1'b1, 1'b1);
    check_time("mode_inc");
    check("mode_inc.mode", mode_o0, 1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) slow_pulse("pre_coin", $urandom_range(1, 12));

    // tick coincident with mode_p in RUN: tick high between E1 and E2
    slow0 = 1'b1;
    step();
    step();
    mode_p0 = 1'b1;
    step();
    mode_p0 = 1'b0;
    m_mode = 1;
    check_time("coincident");
    check("coincident.tick_o", tick_o0, 0);
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 4) slow0 = 1'b0;
      check("coincident.tail.tick_o", tick_o0, 0);
    end
    check_time("coincident.after");
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);

    // random event mix
    for (int k = 0; k < 40; k++) begin
      ev = $urandom_range(0, 5);
      case (ev)
        0, 1, 2: slow_pulse("rnd.slow", $urandom_range(1, 15));
        3: pulse(1'b1, 1'b0);
        4: pulse(1'b0, 1'b1);
        default: pulse(1'b1, 1'b1);
      endcase
      check_time("rnd");
    end

    // reach 12:34:56 and reset in the middle of a pending tick
    set_time(12, 34);
    for (int k = 0; k < 56; k++) slow_pulse("to1234", $urandom_range(1, 12));
    check("at.sec_u", sec_u0, 6);
    slow0 = 1'b1;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    m_secs = 0;
    m_mode = 0;
    check_time("async_rst");
    check("async_rst.tick_o", tick_o0, 0);
    step();
    step();
    check_time("rst_hold");
    // release with slow_in already high: exactly one tick follows
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      cnt += int'(tick_o0);
    end
    m_secs = 1;
    check("rel_high.ticks", cnt, 1);
    check_time("rel_high");
    slow0 = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // both-edges instance: 20-cycle period over 100 cycles gives 10 ticks
    cnt = 0;
    for (int c = 0; c < 106; c++) begin
      slow1 = (c < 100) && ((c % 20) < 10);
      step();
      cnt += int'(tick_o1);
    end
    check("both.ticks", cnt, 10);
    check("both.sec_t", sec_t1, 1);
    check("both.sec_u", sec_u1, 0);
    check("both.min_u", min_u1, 0);
    check("both.hr_u", hr_u1, 0);
    check("both.mode", mode_o1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/watch_timekeeper.md
# watch_timekeeper

Consumer end of the slow-clock interface: takes the divided, free-running toggle signal produced by the design's clock divider and turns it into a BCD 24-hour hh:mm:ss time-of-day. The block samples that signal in the fast `clk` domain and does not use it as a clock. It detects its edges as one-second ticks and maintains the time digits. Two pulse inputs let the user set hours and minutes. Its outputs feed the seven-segment display driver.

## Interface
Parameters:
- `BOTH_EDGES`, default 0: 0 = only a rising edge of `slow_in` is a tick; 1 = both edges are ticks.

Ports:
- `clk` input 1: system clock; all state is clocked on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `slow_in` input 1: toggle output of the clock divider; treated as asynchronous.
- `mode_p` input 1: single-cycle pulse from an upstream debouncer; advances the mode.
- `inc_p` input 1: single-cycle pulse from an upstream debouncer; increments the field being set.
- `hr_t` output 4: hours tens digit, BCD, range 0–2.
- `hr_u` output 4: hours units digit, BCD.
- `min_t` output 4: minutes tens digit, BCD, range 0–5.
- `min_u` output 4: minutes units digit, BCD.
- `sec_t` output 4: seconds tens digit, BCD, range 0–5.
- `sec_u` output 4: seconds units digit, BCD.
- `mode_o` output 2: current mode; 0 = RUN, 1 = SET_HR, 2 = SET_MIN.
- `tick_o` output 1: one-cycle pulse, high in the cycle after a tick was applied.

## Operation
- Synchronizer and edge detect:
  - Registers s1 ← `slow_in`, s2 ← s1, s3 ← s2.
  - tick = (s2 & ~s3); when `BOTH_EDGES`=1, tick = (s2 ^ s3).
- State machine, 2-bit encoding as on `mode_o`:
  - RUN --mode_p--> SET_HR --mode_p--> SET_MIN --mode_p--> RUN.
  - Encoding 3 is unreachable; if it is ever entered, the next edge goes to RUN.
- RUN:
  - Each tick increments the time with BCD carry: sec_u 9→0 carries into sec_t; sec_t 5→0 carries into min_u; min_u 9→0 carries into min_t; min_t 5→0 carries into the hours.
  - Hours sequence is 09→10, 19→20, 23→00.
  - 23:59:59 + tick gives 00:00:00, with no day output.
- SET_HR:
  - Ticks are ignored and `tick_o` stays low.
  - `inc_p` increments the hours 00→01→…→23→00.
  - Minutes and seconds do not change.
- SET_MIN:
  - Ticks are ignored and `tick_o` stays low.
  - `inc_p` increments the minutes 00→…→59→00.
  - There is no carry into the hours.
- Transition SET_MIN→RUN clears sec_t and sec_u to 0 on the same edge.
- Simultaneous events:
  - `mode_p` and `inc_p` in the same cycle: `mode_p` takes effect and `inc_p` is dropped.
  - tick and `mode_p` in the same cycle while in RUN: the mode changes to SET_HR and the tick is dropped, so the time is unchanged.
  - `inc_p` while in RUN has no effect.
- Illegal digit values cannot be produced. Every digit update is a full compare-and-wrap, not a free increment.

## Timing
- Reset, asynchronous, while `rst_n`=0:
  - s1, s2 and s3 = 0.
  - All six digits = 0.
  - `mode_o` = 0 (RUN).
  - `tick_o` = 0.
- `slow_in` sampled high first at edge E0:
  - s1=1 after E0 and s2=1 after E1.
  - tick is high between E1 and E2.
  - The digits update at E2.
  - `tick_o` is high for exactly one cycle, from E2 to E3.
- Latency from `slow_in` transition to digit change is 3 edges, including the metastability edge.
- Pulses longer than one cycle on `slow_in` still produce exactly one tick per qualifying edge.
- `mode_p` or `inc_p` high at edge E: the effect appears at `mode_o` or the digits after E, a 1-cycle latency.
- `slow_in` already high when `rst_n` deasserts: s3=0 causes one tick about 2 cycles after release. This is required behaviour and is counted.
- Reset asserted mid-update: all registers return to their reset values immediately, and no partial carry is retained.

## Test plan
- Reset, then a 00:00:00 preset:
  - Drive `slow_in` with a 20-cycle period, `BOTH_EDGES`=0.
  - Required: 5 ticks → 00:00:05, and each `tick_o` appears exactly 3 edges after the `slow_in` rise.
- Rollover:
  - Set 23:59 via SET_HR/SET_MIN, return to RUN, then issue 59 ticks, then 1 more tick.
  - Required: the display reads 23:59:59 and then 00:00:00, with hr_t=0 and hr_u=0.
- Set mode:
  - From 00:00:00 apply mode_p, then 25×inc_p.
  - Required: hours = 01, reached through 23→00, with minutes unchanged.
  - Then apply mode_p and 61×inc_p.
  - Required: minutes = 01, hours still 01.
  - Then apply mode_p.
  - Required: RUN, with seconds = 00.
- Ticks ignored while setting:
  - In SET_HR, drive 10 `slow_in` edges.
  - Required: the digits stay constant and `tick_o` never asserts.
- Simultaneous inputs:
  - `mode_p` and `inc_p` in the same cycle from RUN.
  - Required: mode becomes 1 and hours are unchanged.
  - Tick coincident with `mode_p` in RUN.
  - Required: seconds are unchanged.
- Edge mode and reset:
  - With `BOTH_EDGES`=1 and a 20-cycle `slow_in` period over 100 cycles: exactly 10 ticks.
  - Assert `rst_n`=0 mid-run at 12:34:56.
  - Required: all outputs are 0 asynchronously, before the next `clk` edge.
